aes_key_expander: RTL

// Iterative AES-128 key-schedule engine that sits upstream of the AES decrypt datapath.
// The AXI register file writes the cipher key into this block. The block expands it into
// 11 round keys, one round per clock, and stores them in an internal bank. The decrypt

---
 rtl/aes_key_expander.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an internal bank,
// with a registered random-access read port for the decrypt datapath.
module aes_key_expander #(
  parameter int unsigned NR    = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic [0:127]     key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [0:127]     rk_out
);

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [7:0]       rcon_q;
  logic [127:0]     bank_q [NR+1];
  logic             done_q, keys_valid_q;
  logic [127:0]     rk_out_q;
  logic             accept, step, last;
  logic [127:0]     prev_rk, next_rk, rd_data;
  logic [31:0]      w3, t, w4, w5, w6, w7;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {fwd_sbox(w[31:24]), fwd_sbox(w[23:16]), fwd_sbox(w[15:8]), fwd_sbox(w[7:0])};
  endfunction

  // Bank muxes: previous round key for expansion, indexed key for the read port.
  always_comb begin
    prev_rk = '0;
    rd_data = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (cnt_q == IDX_W'(i + 1)) prev_rk = bank_q[i];
    end
    for (int unsigned i = 0; i <= NR; i++) begin
      if (rk_idx == IDX_W'(i)) rd_data = bank_q[i];
    end
  end

  // One round of the key schedule from the previous round key.
  always_comb begin
    w3      = prev_rk[31:0];
    t       = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    w4      = prev_rk[127:96] ^ t;
    w5      = prev_rk[95:64] ^ w4;
    w6      = prev_rk[63:32] ^ w5;
    w7      = w3 ^ w6;
    next_rk = {w4, w5, w6, w7};
  end

  // FSM next state and control strobes; start is ignored while expanding.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      StIdle, StReady: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StExpand;
        end
      end
      StExpand: begin
        step = 1'b1;
        if (cnt_q == IDX_W'(NR)) begin
          last    = 1'b1;
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Key capture, round-by-round bank writes, Rcon doubling and status flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q        <= '0;
      rcon_q       <= 8'h00;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      done_q <= last;
      if (accept) begin
        bank_q[0]    <= key_in;
        cnt_q        <= IDX_W'(1);
        rcon_q       <= 8'h01;
        keys_valid_q <= 1'b0;
      end else if (step) begin
        for (int unsigned i = 1; i <= NR; i++) begin
          if (cnt_q == IDX_W'(i)) bank_q[i] <= next_rk;
        end
        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (last) keys_valid_q <= 1'b1;
        else      cnt_q        <= cnt_q + IDX_W'(1);
      end
    end
  end

  // Registered read port; zero while the bank is incomplete or the index is out of range.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rk_out_q <= '0;
    end else if (keys_valid_q && (rk_idx <= IDX_W'(NR))) begin
      rk_out_q <= rd_data;
    end else begin
      rk_out_q <= '0;
    end
  end

  assign busy       = (state_q == StExpand);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_out     = rk_out_q;

endmodule
